disp_channel_sched: RTL and testbench

Sequencing controller for the 8-channel seven-segment display multiplexer on the Nexys4 board. Drives the 3-bit channel select (Test) and the channel-0 latch enable (EN) of the display mux. Supports three modes:
- Manual stepping from buttons.
- Timed auto-rotation over an enable mask.
- Temporary hold on channel 0 whenever the CPU posts fresh display data.

---
 rtl/disp_channel_sched_if.sv | 23 ++
 rtl/disp_channel_sched.sv | 132 +++++++++++++
 tb/tb_disp_channel_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/disp_channel_sched_if.sv
// Control and status bundle between the display sequencer and its surroundings.
// Master drives buttons, mask, mode level and CPU strobe. Slave returns the channel select, latch enable and state.
interface disp_channel_sched_if;
  logic       auto_en;
  logic [7:0] ch_mask;
  logic       btn_next;
  logic       btn_prev;
  logic       cpu_wr;
  logic [2:0] Test;
  logic       EN;
  logic [1:0] mode;
  logic       dbg_ret_auto;

  modport master (
    output auto_en, ch_mask, btn_next, btn_prev, cpu_wr,
    input  Test, EN, mode, dbg_ret_auto
  );

  modport slave (
    input  auto_en, ch_mask, btn_next, btn_prev, cpu_wr,
    output Test, EN, mode, dbg_ret_auto
  );
endinterface

// File: rtl/disp_channel_sched.sv
// Channel sequencer for the 8-digit seven-segment mux.
// Supports manual stepping, timed rotation over an enable mask, and a channel-0 hold after CPU writes.
module disp_channel_sched #(
  parameter int DWELL_CYC = 100000000,
  parameter int HOLD_CYC  = 50000000,
  parameter int CNT_W     = 27
) (
  input logic                  clk,
  input logic                  rst,
  disp_channel_sched_if.slave  bus
);

  // The state encoding is the externally visible mode value.
  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       test_q, test_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             ret_auto_q, ret_auto_d;
  logic             btn_next_q, btn_prev_q;
  logic             arm_q;

  logic [7:0]       eff_mask;
  logic             edge_n, edge_p, step_fwd, step_bwd;
  logic             dwell_done, hold_done;
  logic [2:0]       next_ch, prev_ch;

  // Nearest enabled channel in the given direction (mod 8), or c if none other is enabled.
  function automatic logic [2:0] search(input logic [2:0] c, input logic [7:0] m, input logic up);
    logic [2:0] r;
    logic [2:0] idx;
    r = c;
    for (int i = 7; i >= 1; i--) begin
      idx = up ? (c + 3'(i)) : (c - 3'(i));
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign eff_mask   = bus.ch_mask | 8'h01;
  assign next_ch    = search(test_q, eff_mask, 1'b1);
  assign prev_ch    = search(test_q, eff_mask, 1'b0);
  assign dwell_done = (cnt_q == CNT_W'(DWELL_CYC - 1));
  assign hold_done  = (cnt_q == CNT_W'(HOLD_CYC - 1));

  // Edges are masked for the first cycle after reset so a button already held does not step.
  assign edge_n   = bus.btn_next & ~btn_next_q & arm_q;
  assign edge_p   = bus.btn_prev & ~btn_prev_q & arm_q;
  assign step_fwd = edge_n & ~edge_p;
  assign step_bwd = edge_p & ~edge_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_MANUAL;
      test_q     <= 3'd0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      ret_auto_q <= 1'b0;
      btn_next_q <= 1'b0;
      btn_prev_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      test_q     <= test_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ret_auto_q <= ret_auto_d;
      btn_next_q <= bus.btn_next;
      btn_prev_q <= bus.btn_prev;
      arm_q      <= 1'b1;
    end
  end

  // Next-state logic; branch order is the per-cycle priority.
  always_comb begin
    state_d    = state_q;
    test_d     = test_q;
    cnt_d      = cnt_q;
    ret_auto_d = ret_auto_q;
    en_d       = bus.cpu_wr;
    if (bus.cpu_wr) begin
      state_d    = ST_HOLD;
      test_d     = 3'd0;
      cnt_d      = '0;
      ret_auto_d = bus.auto_en;
    end else if (state_q == ST_HOLD) begin
      if (hold_done) begin
        state_d = bus.auto_en ? ST_AUTO : ST_MANUAL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!eff_mask[test_q]) begin
      test_d = next_ch;
      cnt_d  = '0;
    end else if (step_fwd) begin
      test_d = next_ch;
      cnt_d  = '0;
    end else if (step_bwd) begin
      test_d = prev_ch;
      cnt_d  = '0;
    end else if (state_q == ST_AUTO) begin
      if (dwell_done) begin
        test_d = next_ch;
        cnt_d  = '0;
      end else if (!bus.auto_en) begin
        state_d = ST_MANUAL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      if (bus.auto_en) state_d = ST_AUTO;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.Test         = test_q;
    bus.EN           = en_q;
    bus.mode         = state_q;
    bus.dbg_ret_auto = ret_auto_q;
  end

endmodule

// File: tb/tb_disp_channel_sched.sv
// Randomized bench for disp_channel_sched against a countdown-based reference model.
// Directed segments walk through rotation, manual stepping, hold, mask edits and async reset.
module tb_disp_channel_sched;
  localparam int DWELL = 4;
  localparam int HOLD  = 6;
  localparam int M_MAN = 0, M_AUTO = 1, M_HOLD = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_channel_sched_if bus();

  disp_channel_sched #(.DWELL_CYC(DWELL), .HOLD_CYC(HOLD), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  logic       cur_auto, cur_bn, cur_bp, cur_wr;
  logic [7:0] cur_mask;

  // Reference model state
  int m_mode, m_test, m_left, m_en;
  bit m_pn, m_pp, m_first;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_ch(input int c, input logic [7:0] mask, input int dir);
    int k, ch;
    for (k = 1; k < 8; k++) begin
      ch = (((c + dir * k) % 8) + 8) % 8;
      if (ch == 0 || mask[ch]) return ch;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_mode = M_MAN; m_test = 0; m_en = 0; m_left = DWELL;
    m_pn = 0; m_pp = 0; m_first = 1;
  endtask

  task automatic model_step(input logic a, input logic [7:0] mask, input logic bn, input logic bp, input logic wr);
    bit en_n, en_p, fwd, bwd;
    logic [7:0] em;
    em = mask | 8'h01;
    en_n = bn && !m_pn && !m_first;
    en_p = bp && !m_pp && !m_first;
    m_pn = bn; m_pp = bp; m_first = 0;
    fwd = en_n && !en_p;
    bwd = en_p && !en_n;
    m_en = wr;
    if (wr) begin
      m_mode = M_HOLD; m_test = 0; m_left = HOLD;
    end else if (m_mode == M_HOLD) begin
      if (m_left == 1) begin
        m_mode = a ? M_AUTO : M_MAN; m_left = DWELL;
      end else m_left--;
    end else if (!em[m_test]) begin
      m_test = find_ch(m_test, em, 1); m_left = DWELL;
    end else if (fwd) begin
      m_test = find_ch(m_test, em, 1); m_left = DWELL;
    end else if (bwd) begin
      m_test = find_ch(m_test, em, -1); m_left = DWELL;
    end else if (m_mode == M_AUTO) begin
      if (m_left == 1) begin
        m_test = find_ch(m_test, em, 1); m_left = DWELL;
      end else if (!a) m_mode = M_MAN;
      else m_left--;
    end else if (a) begin
      m_mode = M_AUTO; m_left = DWELL;
    end
  endtask

  // Driver: apply inputs at a falling edge, predict, then compare at the next falling edge.
  task automatic tick();
    logic [5:0] e;
    bus.auto_en = cur_auto; bus.ch_mask = cur_mask;
    bus.btn_next = cur_bn; bus.btn_prev = cur_bp; bus.cpu_wr = cur_wr;
    model_step(cur_auto, cur_mask, cur_bn, cur_bp, cur_wr);
    exp_q.push_back({3'(m_test), 1'(m_en), 2'(m_mode)});
    @(negedge clk);
    e = exp_q.pop_front();
    check("Test", bus.Test, e[5:3]);
    check("EN",   bus.EN,   e[2]);
    check("mode", bus.mode, e[1:0]);
  endtask

  task automatic idle(input int n);
    cur_wr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_next();
    cur_bn = 1'b1; tick();
    cur_bn = 1'b0; tick();
  endtask

  task automatic press_prev();
    cur_bp = 1'b1; tick();
    cur_bp = 1'b0; tick();
  endtask

  task automatic strobe_wr();
    cur_wr = 1'b1; tick();
    cur_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cur_auto = 1'b0; cur_mask = 8'h00; cur_bn = 1'b0; cur_bp = 1'b0; cur_wr = 1'b0;
    bus.auto_en = 1'b0; bus.ch_mask = 8'h00; bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0; bus.cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_Test", bus.Test, 0);
    check("rst_EN",   bus.EN,   0);
    check("rst_mode", bus.mode, 0);
    rst = 1'b0;
    model_reset();

    // Auto rotation over all channels
    cur_mask = 8'hFF; cur_auto = 1'b1;
    idle(36);

    // Manual stepping over a sparse mask
    cur_auto = 1'b0; idle(2);
    cur_wr = 1'b1; tick(); cur_wr = 1'b0;
    idle(HOLD + 1);
    cur_mask = 8'b1010_0100;
    press_next(); press_next(); press_next();
    press_prev(); press_prev();
    cur_bn = 1'b1; cur_bp = 1'b1; tick();
    cur_bn = 1'b0; cur_bp = 1'b0; tick();

    // Hold from mid-dwell, restarted by a second strobe, buttons ignored
    cur_mask = 8'hFF; cur_auto = 1'b1;
    idle(13);
    strobe_wr();
    idle(4);
    strobe_wr();
    press_next();
    idle(12);

    // Disabling the current channel in manual mode
    cur_auto = 1'b0; idle(2);
    strobe_wr(); idle(HOLD + 1);
    for (int i = 0; i < 6; i++) press_next();
    cur_mask = 8'hBF; idle(2);
    cur_mask = 8'h3F; press_next(); press_next(); idle(2);
    cur_mask = 8'h00; cur_auto = 1'b1; idle(12);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) cur_auto = ~cur_auto;
      if ($urandom_range(0, 59) == 0)
        cur_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) cur_bn = ~cur_bn;
      if ($urandom_range(0, 3) == 0) cur_bp = ~cur_bp;
      cur_wr = ($urandom_range(0, 24) == 0);
      tick();
    end

    // Async reset while EN is pending and the hold is active, with btn_next held high
    cur_auto = 1'b0; cur_mask = 8'hFF; cur_bn = 1'b0; cur_bp = 1'b0;
    idle(3);
    strobe_wr();
    cur_bn = 1'b1;
    bus.btn_next = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_Test", bus.Test, 0);
    check("arst_EN",   bus.EN,   0);
    check("arst_mode", bus.mode, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);
    cur_bn = 1'b0; tick();
    cur_bn = 1'b1; tick();
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
